// File: rtl/freq_pkg.sv
// Shared types, width constant and absolute-difference helper for the frequency lock monitor.
package freq_pkg;

    localparam int COUNT_W = 32;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // One extra bit holds the borrow so the difference is exact for any pair of counts.
    function automatic logic [COUNT_W-1:0] abs_diff(input logic [COUNT_W-1:0] a,
                                                    input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[COUNT_W]) begin
            d = -d;
        end
        return d[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/freq_avg_acc.sv
// Block averager: sums 2^AVG_LOG2 strobed counts and publishes the truncated mean.
module freq_avg_acc
    import freq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] cnt,
    input  logic               cnt_valid,
    input  logic               clear,
    output logic [COUNT_W-1:0] freq_avg,
    output logic               avg_valid,
    output logic               avg_done,
    output logic [COUNT_W-1:0] avg_new
);

    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = COUNT_W + AVG_LOG2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic             last;

    // The extra AVG_LOG2 bits absorb a full window of all-ones counts.
    assign sum      = acc + ACC_W'(cnt);
    assign last     = (idx == IDX_LAST);
    assign avg_new  = sum[AVG_LOG2 +: COUNT_W];
    assign avg_done = cnt_valid && !clear && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            idx       <= '0;
            freq_avg  <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                idx <= '0;
            end else if (cnt_valid) begin
                if (last) begin
                    freq_avg  <= avg_new;
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    idx       <= '0;
                end else begin
                    acc <= sum;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/freq_lock_monitor.sv
// Averages frequency-detect counts and tracks lock with hysteresis.
// Optional FREQ_MINMAX_TRACK_EN adds raw min/max count tracking outputs.
module freq_lock_monitor
    import freq_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cnt,
    input  logic        cnt_valid,
    input  logic [31:0] target,
    input  logic [31:0] tol,
    input  logic        clear_stats,
    output logic [31:0] freq_avg,
    output logic        avg_valid,
    output logic        in_tol,
    output logic        lock,
    output logic        lost_lock
`ifdef FREQ_MINMAX_TRACK_EN
    ,
    output logic [31:0] freq_min,
    output logic [31:0] freq_max
`endif
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    // cnt_valid is a one-cycle strobe with no ready: every strobe is consumed,
    // back-to-back strobes included, unless clear_stats is high in that cycle.
    logic               avg_done;
    logic [COUNT_W-1:0] avg_new;
    logic               new_in_tol;

    lock_state_t state;
    lock_state_t state_nxt;
    logic [3:0]  run;
    logic [3:0]  run_nxt;
    logic [3:0]  run_inc;
    logic        lost_nxt;

    freq_avg_acc #(
        .AVG_LOG2(AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .cnt_valid(cnt_valid),
        .clear    (clear_stats),
        .freq_avg (freq_avg),
        .avg_valid(avg_valid),
        .avg_done (avg_done),
        .avg_new  (avg_new)
    );

    assign new_in_tol = (abs_diff(avg_new, target) <= tol);
    assign run_inc    = run + 4'd1;
    assign lock       = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_UNLOCKED;
            run       <= 4'd0;
            lost_lock <= 1'b0;
            in_tol    <= 1'b0;
        end else begin
            state     <= state_nxt;
            run       <= run_nxt;
            lost_lock <= lost_nxt;
            if (avg_done) begin
                in_tol <= new_in_tol;
            end
        end
    end

    // The run counter only moves on completed averages; clearing never reports a lost lock.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        lost_nxt  = 1'b0;
        if (clear_stats) begin
            state_nxt = ST_UNLOCKED;
            run_nxt   = 4'd0;
        end else if (avg_done) begin
            case (state)
                ST_UNLOCKED: begin
                    if (new_in_tol) begin
                        if (run_inc == LOCK_N) begin
                            state_nxt = ST_LOCKED;
                            run_nxt   = 4'd0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!new_in_tol) begin
                        if (run_inc == UNLOCK_N) begin
                            state_nxt = ST_UNLOCKED;
                            run_nxt   = 4'd0;
                            lost_nxt  = 1'b1;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                    run_nxt   = 4'd0;
                end
            endcase
        end
    end

`ifdef FREQ_MINMAX_TRACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_min <= 32'hFFFF_FFFF;
            freq_max <= 32'h0;
        end else if (clear_stats) begin
            freq_min <= 32'hFFFF_FFFF;
            freq_max <= 32'h0;
        end else if (cnt_valid) begin
            if (cnt < freq_min) begin
                freq_min <= cnt;
            end
            if (cnt > freq_max) begin
                freq_max <= cnt;
            end
        end
    end
`endif

endmodule
